// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU control path: opcodes, writeback
// encodings, controller states and the bundled per-instruction controls.
package cpu_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [2:0] OP_ALU_PFX = 3'b001;
  localparam logic [5:0] OP_LI   = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b010001;
  localparam logic [5:0] OP_LWR  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b010011;
  localparam logic [5:0] OP_SWI  = 6'b010100;
  localparam logic [5:0] OP_SWR  = 6'b010101;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_JS   = 6'b100011;
  localparam logic [5:0] OP_JNS  = 6'b100100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_INM = 2'b01;
  localparam logic [1:0] WD_MEM = 2'b10;

  typedef enum logic [1:0] {RUN, FLAGW, FLUSH, HALT} state_t;

  typedef struct packed {
    logic       we3;
    logic       we_flags;
    logic [2:0] op_alu;
    logic [1:0] s_wd3;
    logic       read;
    logic       write;
    logic       s_mem_in;
    logic       s_addr;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Jump condition is carried in the low three opcode bits.
  function automatic logic jump_taken(input logic [2:0] jc, input logic z, input logic s);
    case (jc)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return s;
      3'd4:    return !s;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Purely combinational opcode decode into datapath controls plus the
// classification bits the sequencer needs.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       is_alu,
  output logic       is_jump,
  output logic       is_cond,
  output logic       is_halt,
  output logic [2:0] jcond
);

  always_comb begin
    ctrl    = CTRL_NOP;
    is_alu  = 1'b0;
    is_jump = 1'b0;
    is_cond = 1'b0;
    is_halt = 1'b0;
    jcond   = opcode[2:0];
    case (opcode)
      OP_LI: begin
        ctrl.we3   = 1'b1;
        ctrl.s_wd3 = WD_INM;
      end
      OP_LW, OP_LWR: begin
        ctrl.read   = 1'b1;
        ctrl.we3    = 1'b1;
        ctrl.s_wd3  = WD_MEM;
        ctrl.s_addr = opcode[1];
      end
      OP_SW:  ctrl.write = 1'b1;
      OP_SWI: begin
        ctrl.write    = 1'b1;
        ctrl.s_mem_in = 1'b1;
      end
      OP_SWR: begin
        ctrl.write  = 1'b1;
        ctrl.s_addr = 1'b1;
      end
      OP_J: is_jump = 1'b1;
      OP_JZ, OP_JNZ, OP_JS, OP_JNS: begin
        is_jump = 1'b1;
        is_cond = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: begin
        if (opcode[5:3] == OP_ALU_PFX) begin
          is_alu        = 1'b1;
          ctrl.op_alu   = opcode[2:0];
          ctrl.we3      = 1'b1;
          ctrl.we_flags = 1'b1;
          ctrl.s_wd3    = WD_ALU;
        end
      end
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: decodes the DR opcode and gates it with stall, flag
// wait, post-jump flush and halt handling.
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int FLAG_LAT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       s,
  input  logic       stall,
  output logic       enable_pc,
  output logic       enable_if,
  output logic       flush_if,
  output logic       we3,
  output logic       we_flags,
  output logic [2:0] op_alu,
  output logic [1:0] s_wd3,
  output logic       read,
  output logic       write,
  output logic       s_mem_in,
  output logic       s_addr,
  output logic       s_pc,
  output logic       halted
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0] FLAG_INIT  = 2'(FLAG_LAT);

  state_t     state, state_nxt;
  logic [1:0] flag_cnt, flush_cnt, flush_nxt;
  ctrl_t      dec, ctrl_o;
  logic       is_alu, is_jump, is_cond, is_halt;
  logic [2:0] jcond;
  logic       taken, flag_busy, alu_issue;

  opcode_decoder u_dec (
    .opcode  (opcode),
    .ctrl    (dec),
    .is_alu  (is_alu),
    .is_jump (is_jump),
    .is_cond (is_cond),
    .is_halt (is_halt),
    .jcond   (jcond)
  );

  assign taken     = is_jump && jump_taken(jcond, z, s);
  assign flag_busy = is_cond && (flag_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  // Frozen while halted so the counter still reflects the last ALU issue.
  always_ff @(posedge clk) begin
    if (reset)                  flag_cnt <= 2'd0;
    else if (state != HALT) begin
      if (alu_issue)            flag_cnt <= FLAG_INIT;
      else if (flag_cnt != 2'd0) flag_cnt <= flag_cnt - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    case (state)
      RUN: begin
        if (!stall) begin
          if (flag_busy) state_nxt = FLAGW;
          else if (taken) begin
            flush_nxt = FLUSH_INIT;
            if (FLUSH_INIT != 2'd0) state_nxt = FLUSH;
          end else if (is_halt) state_nxt = HALT;
        end
      end
      FLAGW: if (!stall && flag_cnt == 2'd0) state_nxt = RUN;
      FLUSH: begin
        flush_nxt = (flush_cnt != 2'd0) ? flush_cnt - 2'd1 : 2'd0;
        if (flush_cnt <= 2'd1) state_nxt = RUN;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    ctrl_o    = CTRL_NOP;
    enable_pc = 1'b0;
    enable_if = 1'b0;
    flush_if  = 1'b0;
    s_pc      = 1'b0;
    halted    = 1'b0;
    alu_issue = 1'b0;
    if (reset) begin
      enable_pc = 1'b1;
      enable_if = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (stall || flag_busy) begin
            enable_pc = 1'b0;
          end else if (taken) begin
            s_pc      = 1'b1;
            flush_if  = 1'b1;
            enable_pc = 1'b1;
            enable_if = 1'b1;
          end else if (!is_halt) begin
            ctrl_o    = dec;
            enable_pc = 1'b1;
            enable_if = 1'b1;
            alu_issue = is_alu;
          end
        end
        FLUSH: begin
          flush_if  = 1'b1;
          enable_pc = 1'b1;
          enable_if = 1'b1;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign we3      = ctrl_o.we3;
  assign we_flags = ctrl_o.we_flags;
  assign op_alu   = ctrl_o.op_alu;
  assign s_wd3    = ctrl_o.s_wd3;
  assign read     = ctrl_o.read;
  assign write    = ctrl_o.write;
  assign s_mem_in = ctrl_o.s_mem_in;
  assign s_addr   = ctrl_o.s_addr;

  // No architectural side effect may leak from a bubbled or discarded slot.
  a_no_side_effect: assert property (@(posedge clk) disable iff (reset)
    (stall || state != RUN) |-> !(read || write || we3));

endmodule
